// File: rtl/sine_rom_sequencer.sv
// Phase-accumulator sequencer that reads a registered sine ROM and streams the
// samples out over a valid/ready interface, in counted bursts or continuously.
module sine_rom_sequencer #(
    parameter int WIDTH   = 32,
    parameter int DEPTH   = 64,
    parameter int PHASE_W = 16,
    parameter int CNT_W   = 16,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stop,
    input  logic [PHASE_W-1:0] phase_init,
    input  logic [PHASE_W-1:0] step,
    input  logic [CNT_W-1:0]   count,
    output logic               rom_en,
    output logic [AW-1:0]      rom_addr,
    input  logic [WIDTH-1:0]   rom_data,
    output logic               sample_valid,
    input  logic               sample_ready,
    output logic [WIDTH-1:0]   sample_data,
    output logic               sample_last,
    output logic               busy,
    output logic               done,
    output logic [1:0]         dbg_state_o
);

    // Handshake: a sample transfers on any rising edge where sample_valid and
    // sample_ready are both high; sample_valid and sample_data stay stable
    // until that transfer (or until stop/reset discards the sample).

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [PHASE_W-1:0] phase_q, phase_d;
    logic [PHASE_W-1:0] step_q, step_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [CNT_W-1:0]   issued_q, issued_d;
    logic               v1_q, v1_d;
    logic               last_q, last_d;
    logic               done_q, done_d;

    logic               handshake;
    logic               issue_is_last;

    assign rom_en        = (state_q == RUN) && (!v1_q || sample_ready);
    assign handshake     = v1_q && sample_ready;
    // count of zero means continuous: no read is ever the final one.
    assign issue_is_last = (count_q != '0) && ((issued_q + CNT_W'(1)) == count_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            phase_q  <= '0;
            step_q   <= '0;
            count_q  <= '0;
            issued_q <= '0;
            v1_q     <= 1'b0;
            last_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            step_q   <= step_d;
            count_q  <= count_d;
            issued_q <= issued_d;
            v1_q     <= v1_d;
            last_q   <= last_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q;
        step_d   = step_q;
        count_d  = count_q;
        issued_d = issued_q;
        v1_d     = v1_q;
        last_d   = last_q;
        done_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start && !stop) begin
                    state_d  = RUN;
                    phase_d  = phase_init;
                    step_d   = step;
                    count_d  = count;
                    issued_d = '0;
                    v1_d     = 1'b0;
                    last_d   = 1'b0;
                end
            end
            RUN: begin
                if (stop) begin
                    state_d = IDLE;
                    v1_d    = 1'b0;
                    last_d  = 1'b0;
                end else if (rom_en) begin
                    // A read refills the output stage, so v1 stays set even if
                    // the previous sample is being accepted this same cycle.
                    phase_d  = phase_q + step_q;
                    issued_d = issued_q + CNT_W'(1);
                    v1_d     = 1'b1;
                    if (issue_is_last) begin
                        state_d = DRAIN;
                        last_d  = 1'b1;
                    end
                end else if (handshake) begin
                    v1_d = 1'b0;
                end
            end
            DRAIN: begin
                if (stop) begin
                    state_d = IDLE;
                    v1_d    = 1'b0;
                    last_d  = 1'b0;
                end else if (handshake) begin
                    state_d = IDLE;
                    v1_d    = 1'b0;
                    last_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                v1_d    = 1'b0;
                last_d  = 1'b0;
            end
        endcase
    end

    assign rom_addr     = phase_q[PHASE_W-1 -: AW];
    assign sample_valid = v1_q;
    assign sample_data  = rom_data;
    assign sample_last  = v1_q && last_q;
    assign busy         = (state_q != IDLE);
    assign done         = done_q;
    assign dbg_state_o  = state_q;

endmodule

// File: doc/sine_rom_sequencer.md
SINE_ROM_SEQUENCER -- requirements
Module: sine_rom_sequencer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32: sample width in bits, equal to the ROM data width.
REQ-002 The block SHALL have parameter DEPTH, default 64: ROM entry count, a power of two; AW = $clog2(DEPTH).
REQ-003 The block SHALL have parameter PHASE_W, default 16: phase accumulator width, with PHASE_W >= AW.
REQ-004 The block SHALL have parameter CNT_W, default 16: sample-count width.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 The block SHALL have port start, input, 1 bit: begin a burst; sampled in IDLE only.
REQ-008 The block SHALL have port stop, input, 1 bit: abort the current burst.
REQ-009 The block SHALL have port phase_init, input, PHASE_W bits: starting phase, latched on start.
REQ-010 The block SHALL have port step, input, PHASE_W bits: phase increment per sample, latched on start.
REQ-011 The block SHALL have port count, input, CNT_W bits: samples per burst, latched on start; 0 means continuous.
REQ-012 The block SHALL have port rom_en, output, 1 bit: ROM read enable.
REQ-013 The block SHALL have port rom_addr, output, AW bits: ROM read address.
REQ-014 The block SHALL have port rom_data, input, WIDTH bits: ROM registered read data, which holds its value while rom_en is low.
REQ-015 The block SHALL have port sample_valid, output, 1 bit: sample_data is valid.
REQ-016 The block SHALL have port sample_ready, input, 1 bit: downstream accepts the sample.
REQ-017 The block SHALL have port sample_data, output, WIDTH bits: rom_data passed through combinationally.
REQ-018 The block SHALL have port sample_last, output, 1 bit: marks the final sample of a counted burst.
REQ-019 The block SHALL have port busy, output, 1 bit: state != IDLE.
REQ-020 The block SHALL have port done, output, 1 bit: one-cycle pulse at counted-burst completion.

Function
REQ-021 The block SHALL implement three FSM states: IDLE, RUN, DRAIN.
REQ-022 IDLE SHALL transition to RUN on start=1 and stop=0; on start=1 and stop=1 it SHALL stay in IDLE; start outside IDLE SHALL be ignored.
REQ-023 On the transition to RUN, the block SHALL load phase from phase_init, clear the issued counter, and latch step and count.
REQ-024 The block SHALL drive rom_addr = phase[PHASE_W-1 -: AW] from a register.
REQ-025 The block SHALL drive rom_en = (state==RUN) && (!v1 || sample_ready), where v1 is the internal valid flag of the ROM output stage.
REQ-026 On rom_en=1 the block SHALL update phase <= phase + step modulo 2^PHASE_W (wrap, no saturation), increment issued, and set v1=1.
REQ-027 When rom_en=0 and a sample_valid && sample_ready handshake occurs, the block SHALL clear v1; otherwise v1 SHALL hold.
REQ-028 The block SHALL drive sample_valid = v1.
REQ-029 A stalled sample SHALL keep stable data, because rom_en is low while stalled; samples SHALL never be dropped or duplicated.
REQ-030 The block SHALL provide a latency of 2 cycles from the start edge to the first sample_valid, and a throughput of 1 sample/cycle with sample_ready=1.
REQ-031 On the read that issues sample number count (count != 0), the block SHALL move RUN to DRAIN and register a last flag so that sample_last accompanies that sample.
REQ-032 In DRAIN, on acceptance of the last sample, the block SHALL move to IDLE and pulse done=1 for the next cycle.
REQ-033 With count=0, the block SHALL remain in RUN indefinitely, never asserting sample_last or done.
REQ-034 In RUN or DRAIN, stop=1 SHALL force IDLE, clear v1 and the last flag (sample_valid low the next cycle, any pending sample discarded), and produce no done pulse; stop SHALL take priority over a same-cycle handshake or issue.
REQ-035 The issued counter SHALL be CNT_W bits wide; count = 2^CNT_W-1 SHALL be legal.

Reset
REQ-036 On rst_n=0 the block SHALL immediately, asynchronously, set state=IDLE, phase=0, issued=0, v1=0, last flag=0, and the step/count latches to 0.
REQ-037 During reset the outputs SHALL be rom_en=0, rom_addr=0, sample_valid=0, sample_last=0, busy=0, done=0; sample_data is undefined, as it is meaningful only when sample_valid=1.
REQ-038 Reset asserted mid-burst SHALL abandon the burst with no done pulse.

Verification
REQ-039 Basic burst: phase_init=0, step=0x0400, count=4, ready=1 -> rom_addr 0,1,2,3 on cycles 1-4; sample_valid on cycles 2-5 with mem[0..3]; sample_last on cycle 5; done on cycle 6; busy=0 on cycle 6.
REQ-040 Backpressure: sample_ready=0 for 3 cycles mid-burst -> rom_en=0 and sample_data stable through the stall; the accepted sequence is exactly mem[0..3] with no gaps or duplicates.
REQ-041 Wrap: phase_init=0xFC00, step=0x0400, count=3 -> addresses 63,0,1; sample_last on the 3rd sample.
REQ-042 Continuous/stop: count=0, stop after 10 accepted samples -> IDLE the next cycle; sample_valid=0; no done; a start pulsed while busy earlier was ignored.
REQ-043 Async reset: rst_n low mid-burst, between clock edges -> all outputs zero without waiting for clk; a start after release begins a fresh burst from phase_init.
